// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state codes,
// datapath strobe bundle and the state-to-strobe decode.
package ifetch_pkg;

  localparam int unsigned STATE_W         = 4;
  localparam int unsigned MFC_TIMEOUT_DEF = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PC_OUT   = 4'd1;
  localparam logic [3:0] S_MAR_LD   = 4'd2;
  localparam logic [3:0] S_MEM_REQ  = 4'd3;
  localparam logic [3:0] S_WAIT_MFC = 4'd4;
  localparam logic [3:0] S_MDR_LD   = 4'd5;
  localparam logic [3:0] S_MDR_DRV  = 4'd6;
  localparam logic [3:0] S_IR_LD    = 4'd7;
  localparam logic [3:0] S_NEXT     = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam logic [3:0] S_ERR      = 4'd10;

  typedef struct packed {
    logic pc_out;
    logic mar_en;
    logic mem_en;
    logic mem_rw;
    logic mdr_en_read;
    logic mdr_out;
    logic ir_en;
    logic pc_inc;
    logic busy;
    logic fetch_done;
    logic fetch_err;
  } ctrl_t;

  // Moore decode: every control output is a pure function of the state
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_PC_OUT:   c.pc_out = 1'b1;
      S_MAR_LD:   begin c.pc_out = 1'b1; c.mar_en = 1'b1; end
      S_MEM_REQ:  c.mem_en = 1'b1;
      S_WAIT_MFC: begin c.mem_en = 1'b1; c.mem_rw = 1'b1; end
      S_MDR_LD:   begin c.mem_en = 1'b1; c.mem_rw = 1'b1; c.mdr_en_read = 1'b1; end
      S_MDR_DRV:  begin c.mem_rw = 1'b1; c.mdr_out = 1'b1; end
      S_IR_LD:    begin c.mem_rw = 1'b1; c.mdr_out = 1'b1; c.ir_en = 1'b1; end
      S_NEXT:     c.pc_inc = 1'b1;
      S_DONE:     c.fetch_done = 1'b1;
      S_ERR:      c.fetch_err = 1'b1;
      default:    c = '0;
    endcase
    c.busy = (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
    return c;
  endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// Memory-wait watchdog: counts WAIT_MFC cycles and flags the cycle in which
// the LIMIT-th wait cycle is reached. Used only when IFETCH_TIMEOUT_EN is set.
module ifetch_wdog
  import ifetch_pkg::*;
#(
  parameter int unsigned LIMIT = MFC_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt;

  // expired is registered one cycle early so it is high during wait cycle LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= enable && (cnt == CNT_W'(LIMIT - 2));
      if (clear)
        cnt <= '0;
      else if (enable)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifetch_seq.sv
// Multi-word instruction-fetch control sequencer (Moore FSM, registered strobes).
// Define IFETCH_TIMEOUT_EN to add the memory-wait watchdog and the ERR exit.
module ifetch_seq
  import ifetch_pkg::*;
#(
  parameter int unsigned WORDS_PER_INSTR = 1,
  parameter int unsigned MFC_TIMEOUT     = MFC_TIMEOUT_DEF,
  parameter int unsigned IDX_W           = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             MFC,
  output logic             PC_Out,
  output logic             MAR_EN,
  output logic             mem_EN,
  output logic             mem_RW,
  output logic             MDR_EN_read,
  output logic             MDR_out,
  output logic             IR_EN,
  output logic             pc_inc,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy,
  output logic             fetch_done,
  output logic             fetch_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_INSTR - 1);

  if (WORDS_PER_INSTR == 0 || WORDS_PER_INSTR > 4 || (32'd1 << IDX_W) < WORDS_PER_INSTR ||
      MFC_TIMEOUT < 2 || MFC_TIMEOUT > 255) begin : g_bad_cfg
    $error("ifetch_seq: illegal parameter set");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             wdog_expired;

`ifdef IFETCH_TIMEOUT_EN
  ifetch_wdog #(.LIMIT(MFC_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == S_MEM_REQ),
    .enable  (state_q == S_WAIT_MFC),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next state; strobes are the decode of the next state so they register
  // alongside it and follow the state with no extra latency.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d = S_PC_OUT;
            idx_d   = '0;
          end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end
        end
        S_PC_OUT:   state_d = S_MAR_LD;
        S_MAR_LD:   state_d = S_MEM_REQ;
        S_MEM_REQ:  state_d = S_WAIT_MFC;
        S_WAIT_MFC: begin
          if (MFC)
            state_d = S_MDR_LD;
          else if (wdog_expired)
            state_d = S_ERR;
        end
        S_MDR_LD:   state_d = S_MDR_DRV;
        S_MDR_DRV:  state_d = S_IR_LD;
        S_IR_LD:    state_d = S_NEXT;
        S_NEXT: begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_PC_OUT;
          end else begin
            state_d = S_DONE;
          end
        end
        default:    state_d = S_IDLE;
      endcase
    end
    ctrl_d = ctrl_decode(state_d);
`ifndef IFETCH_TIMEOUT_EN
    ctrl_d.fetch_err = 1'b0;
`endif
  end

  assign PC_Out      = ctrl_q.pc_out;
  assign MAR_EN      = ctrl_q.mar_en;
  assign mem_EN      = ctrl_q.mem_en;
  assign mem_RW      = ctrl_q.mem_rw;
  assign MDR_EN_read = ctrl_q.mdr_en_read;
  assign MDR_out     = ctrl_q.mdr_out;
  assign IR_EN       = ctrl_q.ir_en;
  assign pc_inc      = ctrl_q.pc_inc;
  assign busy        = ctrl_q.busy;
  assign fetch_done  = ctrl_q.fetch_done;
  assign fetch_err   = ctrl_q.fetch_err;
  assign word_idx    = idx_q;

endmodule
